// File: rtl/io_energy_meter_if.sv
// io_energy_meter_if: bundle of the monitored valid/ready channel taps
interface io_energy_meter_if #(
  parameter int NB_PORTS   = 3,
  parameter int DATA_WIDTH = 16
);
  logic [NB_PORTS-1:0]            port_valid;
  logic [NB_PORTS-1:0]            port_ready;
  logic [NB_PORTS-1:0]            port_zero;
  logic [NB_PORTS*DATA_WIDTH-1:0] port_data;
  modport master(output port_valid, port_ready, port_zero, port_data);
  modport slave(input port_valid, port_ready, port_zero, port_data);
endinterface

// File: rtl/io_energy_meter.sv
// io_energy_meter: windowed bit-weighted transfer energy meter; IO_ENERGY_TOGGLE_EN selects toggle-count cost
module io_energy_meter #(
  parameter int                  NB_PORTS       = 3,
  parameter int                  DATA_WIDTH     = 16,
  parameter int                  CNT_WIDTH      = 48,
  parameter int                  XFER_CNT_WIDTH = 32,
  parameter logic [NB_PORTS-1:0] ZERO_SKIP_MASK = NB_PORTS'(1),
  localparam int                 SW             = NB_PORTS > 1 ? $clog2(NB_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      arst,
  io_energy_meter_if.slave          tap,
  input  logic                      start,
  input  logic                      stop,
  output logic                      running,
  output logic [CNT_WIDTH-1:0]      energy_total,
  output logic                      energy_valid,
  output logic                      overflow,
  input  logic [SW-1:0]             rd_sel,
  output logic [XFER_CNT_WIDTH-1:0] rd_xfer_cnt
);
  localparam int IW = $clog2(NB_PORTS*DATA_WIDTH+1);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  state_t state, state_nx;
  logic [NB_PORTS-1:0] fire, live, xfer_sat;
  logic [IW-1:0] cost [NB_PORTS];
  logic [IW-1:0] inc;
  logic [CNT_WIDTH-1:0] acc, acc_nx;
  logic [XFER_CNT_WIDTH-1:0] xfer [NB_PORTS];
  logic [XFER_CNT_WIDTH-1:0] xfer_nx [NB_PORTS];
  logic acc_sat, clr, cnt_en;
  assign fire = tap.port_valid & tap.port_ready;
  assign live = fire & ~(ZERO_SKIP_MASK & tap.port_zero);
`ifdef IO_ENERGY_TOGGLE_EN
  logic [DATA_WIDTH-1:0] prev [NB_PORTS];
  // prev_data tracks every fire, skipped or not, and survives start
  always_ff @(posedge clk or posedge arst)
    if (arst) for (int p = 0; p < NB_PORTS; p++) prev[p] <= '0;
    else for (int p = 0; p < NB_PORTS; p++) if (fire[p]) prev[p] <= tap.port_data[p*DATA_WIDTH +: DATA_WIDTH];
  always_comb
    for (int p = 0; p < NB_PORTS; p++) cost[p] = IW'($countones(tap.port_data[p*DATA_WIDTH +: DATA_WIDTH] ^ prev[p]));
`else
  logic unused_data;
  assign unused_data = ^tap.port_data;
  always_comb
    for (int p = 0; p < NB_PORTS; p++) cost[p] = IW'(DATA_WIDTH);
`endif
  always_comb begin
    inc = '0;
    for (int p = 0; p < NB_PORTS; p++) inc = inc + (live[p] ? cost[p] : '0);
    {acc_sat, acc_nx} = {1'b0, acc} + (CNT_WIDTH+1)'(inc);
    if (acc_sat) acc_nx = '1;
    for (int p = 0; p < NB_PORTS; p++) begin
      {xfer_sat[p], xfer_nx[p]} = {1'b0, xfer[p]} + (XFER_CNT_WIDTH+1)'(fire[p]);
      if (xfer_sat[p]) xfer_nx[p] = '1;
    end
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (start ? COUNT : IDLE) :
               state == COUNT ? (stop ? REPORT : COUNT) : IDLE;
  always_comb begin
    running      = state == COUNT;
    energy_valid = state == REPORT;
    clr          = start & (state == IDLE | (state == COUNT & ~stop));
    cnt_en       = state == COUNT & ~clr;
    rd_xfer_cnt  = int'(rd_sel) < NB_PORTS ? xfer[rd_sel] : '0;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      acc          <= '0;
      overflow     <= 1'b0;
      energy_total <= '0;
      for (int p = 0; p < NB_PORTS; p++) xfer[p] <= '0;
    end else begin
      if (clr) begin
        acc      <= '0;
        overflow <= 1'b0;
        for (int p = 0; p < NB_PORTS; p++) xfer[p] <= '0;
      end else if (cnt_en) begin
        acc      <= acc_nx;
        overflow <= overflow | acc_sat | (|xfer_sat);
        for (int p = 0; p < NB_PORTS; p++) xfer[p] <= xfer_nx[p];
      end
      if (state == COUNT && stop) energy_total <= acc_nx;
    end
endmodule
